// File: rtl/fft_mag_stream.sv
// fft_mag_stream: streams the leading OUT_BINS bins of one in every FRAME_DECIM
// input FFT frames as |re| + |im| magnitudes, with input framing checks.
//
// Build option: define FFT_MAG_SAT_EN to output the 17-bit magnitude saturated
// to 16'hFFFF; otherwise the magnitude is halved (sum[16:1]) and never clips.
//
// Ports
//   sys_clk                    rising-edge clock
//   sys_rst                    asynchronous active-low reset
//   fft_in_real/fft_in_imag    signed 16-bit bin value
//   fft_in_valid/sop/eop       input bin qualifier and frame markers
//   fft_data                   16-bit unsigned magnitude, 2 cycles after its bin
//   fft_valid/fft_sop/fft_eop  output qualifier and frame markers, aligned to data
//   frame_err                  one-cycle pulse on an input framing violation
module fft_mag_stream #(
  parameter int unsigned FFT_LEN     = 256,
  parameter int unsigned OUT_BINS    = 128,
  parameter int unsigned FRAME_DECIM = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] fft_in_real,
  input  logic [15:0] fft_in_imag,
  input  logic        fft_in_valid,
  input  logic        fft_in_sop,
  input  logic        fft_in_eop,
  output logic [15:0] fft_data,
  output logic        fft_valid,
  output logic        fft_sop,
  output logic        fft_eop,
  output logic        frame_err
);

  localparam int unsigned CNT_W = $clog2(FFT_LEN) + 1;
  localparam int unsigned DEC_W = 8;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bin_cnt, bin_cnt_nxt, bin_idx;
  logic [DEC_W-1:0]   decim_cnt, decim_cnt_nxt;
  logic               take, pass_now, fwd, out_sop, out_eop, err;
  logic               last_idx;

  logic [15:0]        abs_re_c, abs_im_c;
  logic [15:0]        abs_re, abs_im;
  logic               s1_valid, s1_sop, s1_eop;
  logic [16:0]        sum_c;
  logic [15:0]        mag_c;

  // Index of the bin being presented; a sop bin always restarts at 0.
  assign bin_idx  = fft_in_sop ? '0 : bin_cnt;
  assign last_idx = (bin_idx == CNT_W'(FFT_LEN - 1));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: sop (re)starts a frame from any state; eop or the last legal
  // index without eop ends it.
  always_comb begin
    state_nxt = state;
    if (fft_in_valid) begin
      if (fft_in_sop)
        state_nxt = (decim_cnt == '0) ? PASS : DROP;
      if ((fft_in_sop || state != IDLE) && (fft_in_eop || last_idx))
        state_nxt = IDLE;
    end
  end

  // Per-bin decisions: forwarding, output markers, framing errors, counters.
  always_comb begin
    take          = 1'b0;
    pass_now      = 1'b0;
    fwd           = 1'b0;
    out_sop       = 1'b0;
    out_eop       = 1'b0;
    err           = 1'b0;
    bin_cnt_nxt   = bin_cnt;
    decim_cnt_nxt = decim_cnt;
    if (fft_in_valid && (fft_in_sop || state != IDLE)) begin
      take        = 1'b1;
      bin_cnt_nxt = bin_idx + CNT_W'(1);
      if (fft_in_sop) begin
        decim_cnt_nxt = (decim_cnt == DEC_W'(FRAME_DECIM - 1)) ? '0 : decim_cnt + DEC_W'(1);
        if (state != IDLE) err = 1'b1;
      end
      pass_now = fft_in_sop ? (decim_cnt == '0) : (state == PASS);
      // Output eop on the last forwarded bin, or early on a short input frame.
      if (pass_now && bin_idx < CNT_W'(OUT_BINS)) begin
        fwd     = 1'b1;
        out_sop = (bin_idx == '0);
        out_eop = fft_in_eop || (bin_idx == CNT_W'(OUT_BINS - 1));
      end
      // Short frame (eop early) or long frame (no eop on the last index).
      if (fft_in_eop != last_idx) err = 1'b1;
    end
  end

  // Two's-complement absolute value; 16'h8000 maps to 32768 unsigned.
  assign abs_re_c = fft_in_real[15] ? 16'(~fft_in_real + 16'd1) : fft_in_real;
  assign abs_im_c = fft_in_imag[15] ? 16'(~fft_in_imag + 16'd1) : fft_in_imag;
  assign sum_c    = 17'(abs_re) + 17'(abs_im);

`ifdef FFT_MAG_SAT_EN
  assign mag_c = sum_c[16] ? 16'hFFFF : sum_c[15:0];
`else
  assign mag_c = 16'(sum_c >> 1);
`endif

  // Counters, error pulse and the two pipeline stages.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      bin_cnt   <= '0;
      decim_cnt <= '0;
      frame_err <= 1'b0;
      abs_re    <= '0;
      abs_im    <= '0;
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      fft_data  <= '0;
      fft_valid <= 1'b0;
      fft_sop   <= 1'b0;
      fft_eop   <= 1'b0;
    end else begin
      if (take) bin_cnt <= bin_cnt_nxt;
      decim_cnt <= decim_cnt_nxt;
      frame_err <= err;
      s1_valid  <= fwd;
      s1_sop    <= out_sop;
      s1_eop    <= out_eop;
      if (fwd) begin
        abs_re <= abs_re_c;
        abs_im <= abs_im_c;
      end
      fft_valid <= s1_valid;
      fft_sop   <= s1_sop;
      fft_eop   <= s1_eop;
      if (s1_valid) fft_data <= mag_c;
    end
  end

endmodule

// File: tb/tb_fft_mag_stream.sv
// Scoreboard bench for fft_mag_stream: a per-bin reference model pushes the
// expected output (with its due cycle) and expected frame_err cycles; a
// negedge monitor pops and compares whatever the DUT produces.
module tb_fft_mag_stream;

  localparam int LEN = 256;
  localparam int OB  = 128;
  localparam int FD  = 4;

  logic        sys_clk, sys_rst;
  logic [15:0] fft_in_real, fft_in_imag;
  logic        fft_in_valid, fft_in_sop, fft_in_eop;
  logic [15:0] fft_data;
  logic        fft_valid, fft_sop, fft_eop, frame_err;

  fft_mag_stream #(.FFT_LEN(LEN), .OUT_BINS(OB), .FRAME_DECIM(FD)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .fft_in_real  (fft_in_real),
    .fft_in_imag  (fft_in_imag),
    .fft_in_valid (fft_in_valid),
    .fft_in_sop   (fft_in_sop),
    .fft_in_eop   (fft_in_eop),
    .fft_data     (fft_data),
    .fft_valid    (fft_valid),
    .fft_sop      (fft_sop),
    .fft_eop      (fft_eop),
    .frame_err    (frame_err)
  );

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_out = 0, n_out_sop = 0, n_out_eop = 0, n_err_seen = 0;
  logic [15:0] first_data [2];

  // Reference model state
  bit m_in_frame = 0;
  bit m_pass = 0;
  int m_decim = 0;
  int m_idx = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("FAIL watchdog: cycle %0d exceeded limit 60000", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mag(input logic signed [15:0] re, input logic signed [15:0] im);
    int r, i, s;
    r = re;
    i = im;
    s = (r < 0 ? -r : r) + (i < 0 ? -i : i);
`ifdef FFT_MAG_SAT_EN
    return (s > 65535) ? 16'hFFFF : 16'(s);
`else
    return 16'(s / 2);
`endif
  endfunction

  task automatic model_bin(input logic [15:0] re, input logic [15:0] im, input logic sop, input logic eop);
    exp_t e;
    if (sop) begin
      if (m_in_frame) err_q.push_back(cyc + 1);
      m_in_frame = 1;
      m_pass     = (m_decim == 0);
      m_decim    = (m_decim + 1) % FD;
      m_idx      = 0;
    end else if (!m_in_frame) begin
      return;
    end else begin
      m_idx++;
    end
    if (m_pass && m_idx < OB) begin
      e.cyc  = cyc + 2;
      e.data = mag(re, im);
      e.sop  = (m_idx == 0);
      e.eop  = (m_idx == OB - 1) || eop;
      exp_q.push_back(e);
    end
    if (eop) begin
      if (m_idx != LEN - 1) err_q.push_back(cyc + 1);
      m_in_frame = 0;
    end else if (m_idx == LEN - 1) begin
      err_q.push_back(cyc + 1);
      m_in_frame = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic drive_bin(input logic [15:0] re, input logic [15:0] im, input logic sop, input logic eop);
    fft_in_real  = re;
    fft_in_imag  = im;
    fft_in_sop   = sop;
    fft_in_eop   = eop;
    fft_in_valid = 1'b1;
    model_bin(re, im, sop, eop);
    @(posedge sys_clk);
    #1;
    fft_in_valid = 1'b0;
    fft_in_sop   = 1'b0;
    fft_in_eop   = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit with_eop, input bit gaps, input bit special);
    logic [15:0] re, im;
    for (int i = 0; i < len; i++) begin
      if (gaps) while ($urandom_range(1, 0) == 1) idle(1);
      re = 16'($urandom);
      im = 16'($urandom);
      if (special && i == 0) begin re = 16'h8000; im = 16'h8000; end
      if (special && i == 1) begin re = 16'd3;    im = 16'hFFFC; end
      drive_bin(re, im, i == 0, with_eop && (i == len - 1));
    end
  endtask

  task automatic send_stray(input int n);
    for (int i = 0; i < n; i++) drive_bin(16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_data"},  32'(fft_data),  32'd0);
    check_val({tag, "_valid"}, 32'(fft_valid), 32'd0);
    check_val({tag, "_sop"},   32'(fft_sop),   32'd0);
    check_val({tag, "_eop"},   32'(fft_eop),   32'd0);
    check_val({tag, "_err"},   32'(frame_err), 32'd0);
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check_val("out_missing", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (fft_valid) begin
        if (n_out < 2) first_data[n_out] = fft_data;
        n_out++;
        if (fft_sop) n_out_sop++;
        if (fft_eop) n_out_eop++;
        if (exp_q.size() == 0) begin
          check_val("out_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("out_cyc",  32'(cyc),      32'(e.cyc));
          check_val("out_data", 32'(fft_data), 32'(e.data));
          check_val("out_sop",  32'(fft_sop),  32'(e.sop));
          check_val("out_eop",  32'(fft_eop),  32'(e.eop));
        end
      end
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        check_val("err_missing", 32'(cyc), 32'(err_q[0]));
        void'(err_q.pop_front());
      end
      if (frame_err) begin
        n_err_seen++;
        if (err_q.size() == 0) check_val("err_unexpected", 32'd1, 32'd0);
        else check_val("err_cyc", 32'(cyc), 32'(err_q.pop_front()));
      end
    end
  end

  task automatic pulse_reset();
    sys_rst = 1'b0;
    exp_q.delete();
    err_q.delete();
    m_in_frame = 0;
    m_pass     = 0;
    m_decim    = 0;
    m_idx      = 0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (3) begin
      @(negedge sys_clk);
      check_val("rst_hold_valid", 32'(fft_valid), 32'd0);
      check_val("rst_hold_data",  32'(fft_data),  32'd0);
    end
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst      = 1'b0;
    fft_in_real  = '0;
    fft_in_imag  = '0;
    fft_in_valid = 1'b0;
    fft_in_sop   = 1'b0;
    fft_in_eop   = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_outputs_zero("rst_init");
    sys_rst = 1'b1;
    @(posedge sys_clk);
    #1;

    // Eight clean frames: frames 0 and 4 pass; frame 0 carries special bins.
    for (int f = 0; f < 8; f++) send_frame(LEN, 1, 0, f == 0);
    idle(4);
`ifdef FFT_MAG_SAT_EN
    check_val("mag_min_pair", 32'(first_data[0]), 32'h0000FFFF);
    check_val("mag_3_m4",     32'(first_data[1]), 32'd7);
`else
    check_val("mag_min_pair", 32'(first_data[0]), 32'h00008000);
    check_val("mag_3_m4",     32'(first_data[1]), 32'd3);
`endif
    check_val("clean_sops", 32'(n_out_sop), 32'd2);
    check_val("clean_eops", 32'(n_out_eop), 32'd2);
    check_val("clean_errs", 32'(n_err_seen), 32'd0);

    // Short passed frame (eop at bin 50), then drops until decim wraps.
    send_frame(51, 1, 0, 0);
    for (int f = 0; f < 3; f++) send_frame(LEN, 1, 0, 0);

    // New sop at bin 200 of a passed frame.
    send_frame(200, 0, 0, 0);
    for (int f = 0; f < 3; f++) send_frame(LEN, 1, 0, 0);

    // New sop at bin 60 of a passed frame: output frame left unterminated.
    send_frame(60, 0, 0, 0);
    for (int f = 0; f < 3; f++) send_frame(LEN, 1, 0, 0);

    // Passed frame with random input gaps.
    send_frame(LEN, 1, 1, 0);
    for (int f = 0; f < 3; f++) send_frame(LEN, 1, 0, 0);

    // Reset after bin 60 of a passed frame; stray bins then a fresh frame.
    send_frame(61, 0, 0, 0);
    pulse_reset();
    send_stray(20);
    send_frame(LEN, 1, 0, 0);

    // Long frame with no eop (dropped), trailing bins land in IDLE.
    send_frame(LEN + 4, 0, 0, 0);
    send_frame(LEN, 1, 0, 0);

    idle(6);
    check_val("sb_drain_out", 32'(exp_q.size()), 32'd0);
    check_val("sb_drain_err", 32'(err_q.size()), 32'd0);
    check_val("total_sops",   32'(n_out_sop),    32'd8);
    check_val("total_eops",   32'(n_out_eop),    32'd6);
    check_val("total_errs",   32'(n_err_seen),   32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
